// File: rtl/avalon_pkt_fifo_if.sv
`default_nettype none
// ============================================================================
// Module   : avalon_st_if
// Purpose  : Avalon-ST message stream bundle (valid, sop, eop, empty, data,
//            rdy) used on both sides of avalon_pkt_fifo.
// Ports    : master drives valid/sop/eop/empty/data and samples rdy;
//            slave samples the payload and drives rdy.
// Revision : 1.0 - initial release
// ============================================================================
interface avalon_st_if #(
    parameter int DATA_WIDTH_IN_BYTES = 16
);
    localparam int EMPTY_W = (DATA_WIDTH_IN_BYTES > 1) ? $clog2(DATA_WIDTH_IN_BYTES) : 1;

    logic                             valid;
    logic                             sop;
    logic                             eop;
    logic [EMPTY_W-1:0]               empty;
    logic [8*DATA_WIDTH_IN_BYTES-1:0] data;
    logic                             rdy;

    modport master (output valid, output sop, output eop, output empty, output data, input  rdy);
    modport slave  (input  valid, input  sop, input  eop, input  empty, input  data, output rdy);
endinterface
`default_nettype wire

// File: rtl/avalon_pkt_fifo.sv
`default_nettype none
// ============================================================================
// Module   : avalon_pkt_fifo
// Purpose  : Store-and-forward Avalon-ST message FIFO. Each message is
//            buffered whole and released only once its eop beat is stored.
//            Messages that alone overflow the buffer are dropped and reported.
// Ports    : clk, rst          - clock, synchronous active-high reset
//            msg_in  (slave)   - input message stream
//            msg_out (master)  - output message stream, gap-free messages
//            msg_count         - complete messages stored, not yet fully read
//            oversize_drop     - one-cycle pulse when a message is discarded
//            level             - (AVALON_PKT_FIFO_LEVEL_EN only) registered
//                                occupancy including uncommitted beats
// Options  : define AVALON_PKT_FIFO_LEVEL_EN to add the level port.
// Revision : 1.0 - initial release
// ============================================================================
module avalon_pkt_fifo #(
    parameter int DATA_WIDTH_IN_BYTES = 16,
    parameter int DEPTH               = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    avalon_st_if.slave             msg_in,
    avalon_st_if.master            msg_out,
    output logic [$clog2(DEPTH):0] msg_count,
`ifdef AVALON_PKT_FIFO_LEVEL_EN
    output logic [$clog2(DEPTH):0] level,
`endif
    output logic                   oversize_drop
);
    localparam int AW      = $clog2(DEPTH);
    localparam int DW      = 8 * DATA_WIDTH_IN_BYTES;
    localparam int EW      = (DATA_WIDTH_IN_BYTES > 1) ? $clog2(DATA_WIDTH_IN_BYTES) : 1;
    localparam int ENTRY_W = DW + EW + 2;
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WRITING  = 2'd1,
        ST_DROPPING = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   commit_ptr_q, commit_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]   msg_count_q, msg_count_d;
    logic          oversize_drop_q, oversize_drop_d;

    // Entry layout: {data, empty, sop, eop}
    logic [ENTRY_W-1:0] mem [DEPTH];
    logic               mem_we;
    logic [ENTRY_W-1:0] mem_wdata;
    logic [ENTRY_W-1:0] rd_entry;

    logic full, drop_now, in_rdy, in_acc, out_valid, out_take, commit_evt, read_eop;

    assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    // With no complete message stored, a full buffer can only be holding the
    // message in progress: it can never fit, so it is abandoned.
    assign drop_now  = (state_q == ST_WRITING) && full && (msg_count_q == '0);
    // During the drop cycle the buffer is being emptied, so the beat on the
    // bus can be swallowed as part of the dropped message without a stall.
    assign in_rdy    = (state_q == ST_DROPPING) || drop_now || !full;
    assign in_acc    = msg_in.valid && in_rdy;
    assign out_valid = (msg_count_q != '0);
    assign rd_entry  = mem[rd_ptr_q[AW-1:0]];
    assign out_take  = out_valid && msg_out.rdy;
    assign read_eop  = out_take && rd_entry[0];
    assign mem_wdata = {msg_in.data, msg_in.empty, msg_in.sop, msg_in.eop};

    always_comb begin
        state_d         = state_q;
        wr_ptr_d        = wr_ptr_q;
        commit_ptr_d    = commit_ptr_q;
        oversize_drop_d = 1'b0;
        mem_we          = 1'b0;
        commit_evt      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // Beats outside a message (no sop seen) are silently discarded.
                if (in_acc && msg_in.sop) begin
                    mem_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + PTR_ONE;
                    if (msg_in.eop) begin
                        commit_evt = 1'b1;
                    end else begin
                        state_d = ST_WRITING;
                    end
                end
            end
            ST_WRITING: begin
                if (drop_now) begin
                    wr_ptr_d        = commit_ptr_q;
                    oversize_drop_d = 1'b1;
                    state_d         = (in_acc && msg_in.eop) ? ST_IDLE : ST_DROPPING;
                end else if (in_acc) begin
                    mem_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + PTR_ONE;
                    if (msg_in.eop) begin
                        commit_evt = 1'b1;
                        state_d    = ST_IDLE;
                    end
                end
            end
            ST_DROPPING: begin
                if (in_acc && msg_in.eop) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // The eop entry itself becomes visible along with the rest.
        if (commit_evt) begin
            commit_ptr_d = wr_ptr_q + PTR_ONE;
        end

        rd_ptr_d = out_take ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;

        unique case ({commit_evt, read_eop})
            2'b10:   msg_count_d = msg_count_q + PTR_ONE;
            2'b01:   msg_count_d = msg_count_q - PTR_ONE;
            default: msg_count_d = msg_count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            wr_ptr_q        <= '0;
            commit_ptr_q    <= '0;
            rd_ptr_q        <= '0;
            msg_count_q     <= '0;
            oversize_drop_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            wr_ptr_q        <= wr_ptr_d;
            commit_ptr_q    <= commit_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            msg_count_q     <= msg_count_d;
            oversize_drop_q <= oversize_drop_d;
        end
    end

    // Storage is deliberately not reset; stale entries are never exposed
    // because the read side only advances over committed messages.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem[wr_ptr_q[AW-1:0]] <= mem_wdata;
        end
    end

`ifdef AVALON_PKT_FIFO_LEVEL_EN
    logic [AW:0] level_q, level_d;

    assign level_d = wr_ptr_d - rd_ptr_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            level_q <= '0;
        end else begin
            level_q <= level_d;
        end
    end

    assign level = level_q;
`endif

    assign msg_in.rdy    = in_rdy;
    assign msg_out.valid = out_valid;
    assign msg_out.data  = rd_entry[ENTRY_W-1 -: DW];
    assign msg_out.empty = rd_entry[EW+1 : 2];
    assign msg_out.sop   = rd_entry[1];
    assign msg_out.eop   = rd_entry[0];
    assign msg_count     = msg_count_q;
    assign oversize_drop = oversize_drop_q;

endmodule
`default_nettype wire

// File: tb/tb_avalon_pkt_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_avalon_pkt_fifo
// Purpose  : Directed self-checking bench for avalon_pkt_fifo (DEPTH=8,
//            16-byte bus). Inputs change 1 time unit after a rising edge;
//            outputs are sampled at that same point, away from the edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_avalon_pkt_fifo;
    localparam int DWB   = 16;
    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] msg_count;
    logic       oversize_drop;
`ifdef AVALON_PKT_FIFO_LEVEL_EN
    logic [3:0] level;
`endif

    int checks   = 0;
    int failures = 0;
    int pulses;

    logic [127:0] exp_d [7];
    logic         exp_e [7];

    avalon_st_if #(.DATA_WIDTH_IN_BYTES(DWB)) in_if ();
    avalon_st_if #(.DATA_WIDTH_IN_BYTES(DWB)) out_if ();

    avalon_pkt_fifo #(.DATA_WIDTH_IN_BYTES(DWB), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .msg_in        (in_if),
        .msg_out       (out_if),
        .msg_count     (msg_count),
`ifdef AVALON_PKT_FIFO_LEVEL_EN
        .level         (level),
`endif
        .oversize_drop (oversize_drop)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic s, input logic e,
                         input logic [3:0] emp, input logic [127:0] d);
        in_if.valid = v;
        in_if.sop   = s;
        in_if.eop   = e;
        in_if.empty = emp;
        in_if.data  = d;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        out_if.rdy = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 4'd0, 128'h0);
        tick();
        tick();
        rst = 1'b0;
        chk("rst_count", msg_count, 0);
        chk("rst_valid", out_if.valid, 0);
        chk("rst_rdy", in_if.rdy, 1);
        chk("rst_drop", oversize_drop, 0);

        // 3-beat message, output ready
        drive(1'b1, 1'b1, 1'b0, 4'd0, 128'hA0);
        tick();
        chk("m3_valid_b0", out_if.valid, 0);
        drive(1'b1, 1'b0, 1'b0, 4'd0, 128'hA1);
        tick();
        chk("m3_valid_b1", out_if.valid, 0);
        drive(1'b1, 1'b0, 1'b1, 4'd5, 128'hA2);
        tick();
        drive(1'b0, 1'b0, 1'b0, 4'd0, 128'h0);
        chk("m3_valid", out_if.valid, 1);
        chk("m3_count1", msg_count, 1);
        chk("m3_d0", out_if.data, 128'hA0);
        chk("m3_sop0", out_if.sop, 1);
        tick();
        chk("m3_d1", out_if.data, 128'hA1);
        chk("m3_sop1", out_if.sop, 0);
        tick();
        chk("m3_d2", out_if.data, 128'hA2);
        chk("m3_eop2", out_if.eop, 1);
        chk("m3_empty2", out_if.empty, 5);
        tick();
        chk("m3_count0", msg_count, 0);
        chk("m3_valid0", out_if.valid, 0);

        // 1-beat message
        drive(1'b1, 1'b1, 1'b1, 4'd2, 128'hE0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 4'd0, 128'h0);
        chk("m1_valid", out_if.valid, 1);
        chk("m1_count", msg_count, 1);
        chk("m1_data", out_if.data, 128'hE0);
        tick();
        chk("m1_count0", msg_count, 0);
        chk("m1_valid0", out_if.valid, 0);

        // Simultaneous commit and eop-read with msg_count=1
        out_if.rdy = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 4'd0, 128'hB0);
        tick();
        chk("sim_count_a", msg_count, 1);
        drive(1'b1, 1'b1, 1'b0, 4'd0, 128'hC0);
        tick();
        chk("sim_count_b", msg_count, 1);
        chk("sim_data_a", out_if.data, 128'hB0);
        drive(1'b1, 1'b0, 1'b1, 4'd0, 128'hC1);
        out_if.rdy = 1'b1;
        tick();
        drive(1'b0, 1'b0, 1'b0, 4'd0, 128'h0);
        chk("sim_count_c", msg_count, 1);
        chk("sim_data_c0", out_if.data, 128'hC0);
        tick();
        chk("sim_data_c1", out_if.data, 128'hC1);
        tick();
        chk("sim_count_end", msg_count, 0);

        // Oversize: 12 beats into an 8-deep buffer
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, (i == 0), (i == 11), 4'd0, 128'h100 + 128'(i));
            chk("ovs_rdy", in_if.rdy, 1);
            tick();
            if (oversize_drop === 1'b1) pulses++;
            chk("ovs_valid", out_if.valid, 0);
        end
        drive(1'b0, 1'b0, 1'b0, 4'd0, 128'h0);
        tick();
        chk("ovs_pulses", pulses, 1);
        chk("ovs_drop_low", oversize_drop, 0);
        chk("ovs_count", msg_count, 0);
        drive(1'b1, 1'b1, 1'b0, 4'd0, 128'hF0);
        tick();
        drive(1'b1, 1'b0, 1'b1, 4'd7, 128'hF1);
        tick();
        drive(1'b0, 1'b0, 1'b0, 4'd0, 128'h0);
        chk("ovs_next_valid", out_if.valid, 1);
        chk("ovs_next_d0", out_if.data, 128'hF0);
        tick();
        chk("ovs_next_d1", out_if.data, 128'hF1);
        chk("ovs_next_empty", out_if.empty, 7);
        tick();
        chk("ovs_next_done", out_if.valid, 0);

        // Back-pressure: 5-beat message stored, 4-beat message stalls after 3
        out_if.rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, (i == 0), (i == 4), 4'd0, 128'h200 + 128'(i));
            chk("bp_g_rdy", in_if.rdy, 1);
            tick();
        end
        chk("bp_g_count", msg_count, 1);
`ifdef AVALON_PKT_FIFO_LEVEL_EN
        chk("bp_level", level, 5);
`endif
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, (i == 0), 1'b0, 4'd0, 128'h300 + 128'(i));
            chk("bp_h_rdy", in_if.rdy, 1);
            tick();
        end
        drive(1'b1, 1'b0, 1'b1, 4'd0, 128'h303);
        chk("bp_full_rdy", in_if.rdy, 0);
        chk("bp_g0", out_if.data, 128'h200);
        out_if.rdy = 1'b1;
        tick();
        chk("bp_rdy_back", in_if.rdy, 1);
        chk("bp_g1", out_if.data, 128'h201);
        tick();
        drive(1'b0, 1'b0, 1'b0, 4'd0, 128'h0);
        exp_d[0] = 128'h202; exp_e[0] = 1'b0;
        exp_d[1] = 128'h203; exp_e[1] = 1'b0;
        exp_d[2] = 128'h204; exp_e[2] = 1'b1;
        exp_d[3] = 128'h300; exp_e[3] = 1'b0;
        exp_d[4] = 128'h301; exp_e[4] = 1'b0;
        exp_d[5] = 128'h302; exp_e[5] = 1'b0;
        exp_d[6] = 128'h303; exp_e[6] = 1'b1;
        for (int k = 0; k < 7; k++) begin
            chk("bp_out_data", out_if.data, exp_d[k]);
            chk("bp_out_eop", out_if.eop, exp_e[k]);
            chk("bp_out_count", msg_count, (k < 3) ? 2 : 1);
            chk("bp_no_drop", oversize_drop, 0);
            tick();
        end
        chk("bp_count_end", msg_count, 0);
        chk("bp_valid_end", out_if.valid, 0);

        // Reset mid-WRITING with two committed messages
        out_if.rdy = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 4'd0, 128'h400);
        tick();
        drive(1'b1, 1'b1, 1'b1, 4'd0, 128'h401);
        tick();
        drive(1'b1, 1'b1, 1'b0, 4'd0, 128'h402);
        tick();
        drive(1'b1, 1'b0, 1'b0, 4'd0, 128'h403);
        tick();
        chk("rw_count2", msg_count, 2);
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 4'd0, 128'h0);
        tick();
        rst = 1'b0;
        chk("rw_count0", msg_count, 0);
        chk("rw_valid0", out_if.valid, 0);
        chk("rw_rdy", in_if.rdy, 1);
        drive(1'b1, 1'b0, 1'b0, 4'd0, 128'h500);
        tick();
        chk("rw_nonsop_valid", out_if.valid, 0);
        drive(1'b1, 1'b0, 1'b1, 4'd0, 128'h501);
        tick();
        chk("rw_nonsop_count", msg_count, 0);
        out_if.rdy = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 4'd0, 128'h600);
        tick();
        drive(1'b1, 1'b0, 1'b1, 4'd3, 128'h601);
        tick();
        drive(1'b0, 1'b0, 1'b0, 4'd0, 128'h0);
        chk("rw_n_valid", out_if.valid, 1);
        chk("rw_n_count", msg_count, 1);
        chk("rw_n_d0", out_if.data, 128'h600);
        chk("rw_n_sop", out_if.sop, 1);
        tick();
        chk("rw_n_d1", out_if.data, 128'h601);
        chk("rw_n_empty", out_if.empty, 3);
        chk("rw_n_eop", out_if.eop, 1);
        tick();
        chk("rw_n_done", out_if.valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/avalon_pkt_fifo.md
# avalon_pkt_fifo

Store-and-forward message FIFO for Avalon-ST. Sits directly downstream of the message enforcer: it accepts enforced messages, buffers each one whole, and releases it only after its eop has been stored, so the consumer always sees a gap-free message. Messages longer than the buffer are dropped whole and reported.

## Interface
- DATA_WIDTH_IN_BYTES, 16: data bus width in bytes; `empty` width is $clog2(DATA_WIDTH_IN_BYTES).
- DEPTH, 64: buffer depth in beats; power of 2, ≥4.
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  reset, synchronous and active-high.
- msg_in  avalon_st_if.slave  –  input stream (valid, sop, eop, empty, data, rdy).
- msg_out  avalon_st_if.master  –  output stream.
- msg_count  out  $clog2(DEPTH)+1  complete messages stored and not yet fully read.
- oversize_drop  out  1  one-cycle pulse when a message is discarded for exceeding DEPTH.

## Operation
- Storage: DEPTH entries of {data, empty, sop, eop}. Asynchronous read at rd_ptr.
- Pointers: wr_ptr (tentative), commit_ptr, rd_ptr; each $clog2(DEPTH)+1 bits, MSB is the wrap bit. Full when wr_ptr and rd_ptr differ only in MSB. free = DEPTH − (wr_ptr − rd_ptr).
- Input beat accepted = msg_in.valid & msg_in.rdy.
- Write FSM:
  - IDLE: accepted beat with sop=1 → written at wr_ptr; if eop=1 also → commit (stay IDLE), else → WRITING. Accepted beat with sop=0 → discarded.
  - WRITING: each accepted beat written; eop=1 → commit, → IDLE.
  - Full while in WRITING with msg_count=0 (message alone fills buffer): wr_ptr ← commit_ptr, oversize_drop=1 for one cycle, → DROPPING.
  - DROPPING: accepted beats discarded; eop=1 → IDLE.
- Commit: commit_ptr ← wr_ptr+1 (the eop entry included), msg_count +1.
- msg_in.rdy: 1 in DROPPING; otherwise 1 when not full. When full and msg_count>0, rdy=0 until the read side frees space.
- Read side: msg_out.valid = (msg_count>0). msg_out fields = mem[rd_ptr]. Beat taken when valid & rdy: rd_ptr+1; if the entry has eop, msg_count −1.
- msg_count update on the same edge as commit and eop-read: net 0 if both happen.
- Output never exposes uncommitted entries; rd_ptr never passes commit_ptr.

## Timing
- Reset (rst=1 at a rising edge): all pointers 0, msg_count 0, state IDLE, oversize_drop 0, msg_out.valid 0; msg_in.rdy 1 in the cycle after. Buffer contents are not cleared. A message in progress is lost, and later beats are discarded until the next sop.
- Latency: eop accepted at edge N, so msg_out.valid=1 in the cycle after edge N, carrying that message's sop beat. Minimum one cycle for a 1-beat message.
- Throughput: one beat per cycle in and out, concurrently.
- The full-entry check uses registered pointers. The drop transition happens on the edge after the buffer became full; no beat is lost except the dropped message's.
- msg_out fields are don't-care when valid=0, but are held stable while valid=1 and rdy=0.

## Configuration
- AVALON_PKT_FIFO_LEVEL_EN defined: adds output port `level` ($clog2(DEPTH)+1 bits) = wr_ptr − rd_ptr, registered, reset 0. This count includes uncommitted beats.
- Not defined: no `level` port and no related logic. All other behaviour is identical.

## Test plan
- Single 3-beat message, rdy=1 out, DATA_WIDTH_IN_BYTES=16 → valid rises one cycle after the eop beat; 3 beats out unchanged; last beat empty=5 preserved; msg_count 1→0.
- 1-beat message (sop=eop=1) → appears out the next cycle; msg_count pulses 1 for one cycle.
- DEPTH=8, 12-beat message, no stored messages → oversize_drop pulses once, rdy stays 1, nothing is output. The following 2-beat message passes intact.
- DEPTH=8, msg_out.rdy=0, store a 5-beat message then start a 4-beat one → rdy drops after 3 beats of the second message. Raise msg_out.rdy, and both messages are output in order, no drop.
- Simultaneous eop in and eop out with msg_count=1 → msg_count stays 1.
- Assert rst mid-WRITING with 2 committed messages → next cycle msg_count=0, valid=0. A non-sop beat is discarded, and the following sop message is stored normally.
